// File: rtl/game_pkg.sv
// Shared types and default timing for the multi-round game sequencer.
// Combinational helpers only; no latency or flow control.
package game_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_RUN,
    ST_CAPTURE,
    ST_ANSWER,
    ST_JUDGE,
    ST_RESULT,
    ST_DONE
  } state_t;

  localparam int unsigned DEF_NUM_ROUNDS     = 5;
  localparam int unsigned DEF_BASE_MAX       = 100_000_000;
  localparam int unsigned DEF_MAX_STEP       = 10_000_000;
  localparam int unsigned DEF_MIN_MAX        = 20_000_000;
  localparam int unsigned DEF_MAX_LEVEL      = 9;
  localparam int unsigned DEF_ANSWER_TIMEOUT = 1_000_000_000;
  localparam int unsigned DEF_RESULT_HOLD    = 200_000_000;

  localparam int SCORE_W = 16;
  localparam int LEVEL_W = 4;
  localparam int ROUND_W = 4;
  localparam int SYM_W   = 32;
  localparam int CNT_W   = 8;
  localparam int TIMER_W = 32;

  // A product larger than base would wrap if subtracted unchecked, so it clamps to the floor.
  function automatic logic [SYM_W-1:0] calc_sym_max(input logic [LEVEL_W-1:0] lvl,
                                                   input logic [SYM_W-1:0]   base,
                                                   input logic [SYM_W-1:0]   step,
                                                   input logic [SYM_W-1:0]   floor_v);
    logic [SYM_W-1:0] prod;
    prod = {{(SYM_W-LEVEL_W){1'b0}}, lvl} * step;
    if ((prod > base) || ((base - prod) < floor_v)) begin
      return floor_v;
    end
    return base - prod;
  endfunction

endpackage

// File: rtl/game_round_ctrl_if.sv
// Player/period-block signals seen by the round sequencer.
// Pulse-based, no backpressure: every input pulse is sampled once.
interface game_round_ctrl_if;
  import game_pkg::*;

  logic                 startBtn;
  logic                 abortBtn;
  logic                 answerSig;
  logic [CNT_W-1:0]     numSpecial;
  logic                 guessValid;
  logic [CNT_W-1:0]     guess;
  logic                 gameSig;
  logic [SYM_W-1:0]     symGenMax;
  logic [LEVEL_W-1:0]   level;
  logic [SCORE_W-1:0]   score;
  logic [ROUND_W-1:0]   roundIdx;
  logic                 busy;
  logic                 resultValid;
  logic                 correct;
  logic                 gameOver;

  modport master (
    output startBtn, abortBtn, answerSig, numSpecial, guessValid, guess,
    input  gameSig, symGenMax, level, score, roundIdx, busy, resultValid, correct, gameOver
  );

  modport slave (
    input  startBtn, abortBtn, answerSig, numSpecial, guessValid, guess,
    output gameSig, symGenMax, level, score, roundIdx, busy, resultValid, correct, gameOver
  );

endinterface

// File: rtl/round_timer.sv
// Loadable down-counter; o_done is high while the count sits at zero.
// Load lands next cycle; counting pauses while i_en is low.
module round_timer #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_load,
  input  logic [W-1:0] i_load_val,
  input  logic         i_en,
  output logic         o_done
);

  logic [W-1:0] r_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= i_load_val;
    end else if (i_en && (r_cnt != '0)) begin
      r_cnt <= r_cnt - 1'b1;
    end
  end

  assign o_done = (r_cnt == '0);

endmodule

// File: rtl/game_round_ctrl.sv
// Multi-round game sequencer: starts periods, scores guesses, adapts symbol interval.
// gameSig one cycle after a start edge; inputs are pulses, no backpressure.
module game_round_ctrl
  import game_pkg::*;
#(
  parameter int unsigned NUM_ROUNDS     = DEF_NUM_ROUNDS,
  parameter int unsigned BASE_MAX       = DEF_BASE_MAX,
  parameter int unsigned MAX_STEP       = DEF_MAX_STEP,
  parameter int unsigned MIN_MAX        = DEF_MIN_MAX,
  parameter int unsigned MAX_LEVEL      = DEF_MAX_LEVEL,
  parameter int unsigned ANSWER_TIMEOUT = DEF_ANSWER_TIMEOUT,
  parameter int unsigned RESULT_HOLD    = DEF_RESULT_HOLD
) (
  input  logic              Clk100M,
  input  logic              nRst,
  game_round_ctrl_if.slave  io_bus
);

  localparam logic [SYM_W-1:0]   P_BASE    = SYM_W'(BASE_MAX);
  localparam logic [SYM_W-1:0]   P_STEP    = SYM_W'(MAX_STEP);
  localparam logic [SYM_W-1:0]   P_FLOOR   = SYM_W'(MIN_MAX);
  localparam logic [LEVEL_W-1:0] P_MAX_LVL = LEVEL_W'(MAX_LEVEL);
  localparam logic [ROUND_W-1:0] P_ROUNDS  = ROUND_W'(NUM_ROUNDS);
  localparam logic [TIMER_W-1:0] P_ANS_LD  = TIMER_W'(ANSWER_TIMEOUT - 1);
  localparam logic [TIMER_W-1:0] P_HOLD_LD = TIMER_W'(RESULT_HOLD - 1);

  state_t               r_state;
  state_t               w_next;
  logic                 r_start_prev;
  logic [CNT_W-1:0]     r_target;
  logic [CNT_W-1:0]     r_guess;
  logic                 r_timeout;
  logic                 r_correct;
  logic [SCORE_W-1:0]   r_score;
  logic [LEVEL_W-1:0]   r_level;
  logic [ROUND_W-1:0]   r_round;
  logic [SYM_W-1:0]     r_sym_max;

  logic                 w_start_edge;
  logic                 w_abort;
  logic                 w_correct;
  logic [SCORE_W:0]     w_score_sum;
  logic [LEVEL_W-1:0]   w_new_level;
  logic                 w_tmr_load;
  logic [TIMER_W-1:0]   w_tmr_val;
  logic                 w_tmr_en;
  logic                 w_tmr_done;

  assign w_start_edge = io_bus.startBtn && !r_start_prev;
  assign w_abort      = io_bus.abortBtn && (r_state != ST_IDLE);

  round_timer #(.W(TIMER_W)) u_timer (
    .clk        (Clk100M),
    .rst_n      (nRst),
    .i_load     (w_tmr_load),
    .i_load_val (w_tmr_val),
    .i_en       (w_tmr_en),
    .o_done     (w_tmr_done)
  );

  always_ff @(posedge Clk100M or negedge nRst) begin
    if (!nRst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // The timer is shared: loaded in CAPTURE for the answer window, in JUDGE for the result hold.
  always_comb begin
    w_next     = r_state;
    w_tmr_load = 1'b0;
    w_tmr_val  = '0;
    w_tmr_en   = 1'b0;
    case (r_state)
      ST_IDLE, ST_DONE: if (w_start_edge) w_next = ST_START;
      ST_START:         w_next = ST_RUN;
      ST_RUN:           if (io_bus.answerSig) w_next = ST_CAPTURE;
      ST_CAPTURE: begin
        w_tmr_load = 1'b1;
        w_tmr_val  = P_ANS_LD;
        w_next     = ST_ANSWER;
      end
      ST_ANSWER: begin
        w_tmr_en = 1'b1;
        if (io_bus.guessValid || w_tmr_done) w_next = ST_JUDGE;
      end
      ST_JUDGE: begin
        w_tmr_load = 1'b1;
        w_tmr_val  = P_HOLD_LD;
        w_next     = ST_RESULT;
      end
      ST_RESULT: begin
        w_tmr_en = 1'b1;
        if (w_tmr_done) w_next = (r_round == P_ROUNDS) ? ST_DONE : ST_START;
      end
      default:          w_next = ST_IDLE;
    endcase
    if (w_abort) w_next = ST_IDLE;
  end

  always_comb begin
    w_correct   = !r_timeout && (r_guess == r_target);
    w_score_sum = {1'b0, r_score} + {{(SCORE_W+1-LEVEL_W){1'b0}}, r_level} + 1'b1;
    if (w_correct) begin
      w_new_level = (r_level >= P_MAX_LVL) ? P_MAX_LVL : r_level + 1'b1;
    end else begin
      w_new_level = (r_level == '0) ? '0 : r_level - 1'b1;
    end
  end

  always_ff @(posedge Clk100M or negedge nRst) begin
    if (!nRst) begin
      r_start_prev <= 1'b0;
      r_target     <= '0;
      r_guess      <= '0;
      r_timeout    <= 1'b0;
      r_correct    <= 1'b0;
      r_score      <= '0;
      r_level      <= '0;
      r_round      <= '0;
      r_sym_max    <= P_BASE;
    end else begin
      r_start_prev <= io_bus.startBtn;
      if (!w_abort) begin
        case (r_state)
          ST_IDLE, ST_DONE: begin
            if (w_start_edge) begin
              r_score   <= '0;
              r_level   <= '0;
              r_round   <= '0;
              r_sym_max <= P_BASE;
            end
          end
          ST_CAPTURE: begin
            r_target  <= io_bus.numSpecial;
            r_timeout <= 1'b0;
          end
          // A guess arriving on the expiry cycle still counts.
          ST_ANSWER: begin
            if (io_bus.guessValid) begin
              r_guess <= io_bus.guess;
            end else if (w_tmr_done) begin
              r_timeout <= 1'b1;
            end
          end
          ST_JUDGE: begin
            r_correct <= w_correct;
            if (w_correct) begin
              r_score <= w_score_sum[SCORE_W] ? {SCORE_W{1'b1}} : w_score_sum[SCORE_W-1:0];
            end
            r_level   <= w_new_level;
            r_round   <= r_round + 1'b1;
            r_sym_max <= calc_sym_max(w_new_level, P_BASE, P_STEP, P_FLOOR);
          end
          default: ;
        endcase
      end
    end
  end

  assign io_bus.gameSig     = (r_state == ST_START);
  assign io_bus.busy        = (r_state != ST_IDLE) && (r_state != ST_DONE);
  assign io_bus.resultValid = (r_state == ST_RESULT);
  assign io_bus.gameOver    = (r_state == ST_DONE);
  assign io_bus.correct     = r_correct;
  assign io_bus.score       = r_score;
  assign io_bus.level       = r_level;
  assign io_bus.roundIdx    = r_round;
  assign io_bus.symGenMax   = r_sym_max;

endmodule

// File: tb/tb_game_round_ctrl.sv
// Randomized scenario bench for game_round_ctrl against an arithmetic score/level model.
module tb_game_round_ctrl;

  localparam int ROUNDS = 3;
  localparam int BASE   = 1000;
  localparam int STEP   = 200;
  localparam int MINM   = 400;
  localparam int MAXL   = 7;
  localparam int TMO    = 50;
  localparam int HOLD   = 4;

  logic clk = 1'b0;
  logic rst_n;
  int   n_tests;
  int   n_fail;
  int   m_score, m_level, m_round, m_sym;

  game_round_ctrl_if bus ();

  game_round_ctrl #(
    .NUM_ROUNDS(ROUNDS), .BASE_MAX(BASE), .MAX_STEP(STEP), .MIN_MAX(MINM),
    .MAX_LEVEL(MAXL), .ANSWER_TIMEOUT(TMO), .RESULT_HOLD(HOLD)
  ) dut (
    .Clk100M (clk),
    .nRst    (rst_n),
    .io_bus  (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #500_000;
    $display("FAIL watchdog: simulation did not finish, want completion");
    $fatal(1);
  end

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic model_new_game();
    m_score = 0; m_level = 0; m_round = 0; m_sym = BASE;
  endtask

  task automatic model_round(input bit corr);
    if (corr) begin
      m_score = m_score + m_level + 1;
      if (m_score > 65535) m_score = 65535;
      m_level = (m_level + 1 > MAXL) ? MAXL : m_level + 1;
    end else begin
      m_level = (m_level > 0) ? m_level - 1 : 0;
    end
    m_round++;
    m_sym = BASE - m_level * STEP;
    if (m_sym < MINM) m_sym = MINM;
  endtask

  task automatic start_game(output bit ok, output int lat);
    bus.startBtn = 1'b0;
    tick();
    bus.startBtn = 1'b1;
    lat = 0;
    while (bus.gameSig !== 1'b1 && lat < 10) begin
      tick();
      lat++;
    end
    ok = (bus.gameSig === 1'b1);
  endtask

  // Drives one round from START (or RUN when in_run) to the first RESULT cycle, then through the hold.
  task automatic play_round(input bit in_run, input logic [7:0] ns, input bit do_guess,
                            input logic [7:0] g, input int delay, input bit late,
                            output bit ok, output int ans, output int hold,
                            output logic corr, output logic [15:0] sc, output logic [3:0] lv,
                            output logic [31:0] sym, output logic [3:0] rd);
    int n;
    ok = 1'b1; ans = 0; hold = 0; corr = 1'bx; sc = 'x; lv = 'x; sym = 'x; rd = 'x;
    if (!in_run) begin
      n = 0;
      while (bus.gameSig !== 1'b1 && n < 200) begin tick(); n++; end
      if (bus.gameSig !== 1'b1) begin ok = 1'b0; return; end
      tick();
    end
    bus.guessValid = 1'b1;
    bus.guess      = ns;
    tick($urandom_range(1, 4));
    bus.guessValid = 1'b0;
    bus.numSpecial = ns;
    bus.answerSig  = 1'b1;
    tick();
    bus.answerSig  = 1'b0;
    tick();
    bus.numSpecial = 8'($urandom);
    if (do_guess) begin
      tick(delay);
      bus.guess      = g;
      bus.guessValid = 1'b1;
      tick();
      bus.guessValid = 1'b0;
      ans = delay + 1;
    end
    n = 0;
    while (bus.resultValid !== 1'b1 && n < 200) begin tick(); n++; ans++; end
    if (bus.resultValid !== 1'b1) begin ok = 1'b0; return; end
    corr = bus.correct; sc = bus.score; lv = bus.level; sym = bus.symGenMax; rd = bus.roundIdx;
    while (bus.resultValid === 1'b1 && hold < 50) begin
      if (late && hold == 0) begin
        bus.guess      = ns;
        bus.guessValid = 1'b1;
      end
      tick();
      bus.guessValid = 1'b0;
      hold++;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #23;
    n_tests++; if (bus.symGenMax !== 32'(BASE)) begin n_fail++; $display("FAIL reset_sym: got %0d want %0d", bus.symGenMax, BASE); end
    n_tests++; if (bus.score !== 16'd0) begin n_fail++; $display("FAIL reset_score: got %0d want 0", bus.score); end
    n_tests++; if (bus.level !== 4'd0 || bus.roundIdx !== 4'd0) begin n_fail++; $display("FAIL reset_level_round: got %0d/%0d want 0/0", bus.level, bus.roundIdx); end
    n_tests++; if ({bus.gameSig, bus.busy, bus.resultValid, bus.correct, bus.gameOver} !== 5'b0) begin
      n_fail++; $display("FAIL reset_flags: got %b want 00000", {bus.gameSig, bus.busy, bus.resultValid, bus.correct, bus.gameOver});
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    tick(3);
    n_tests++; if (bus.busy !== 1'b0 || bus.gameSig !== 1'b0) begin n_fail++; $display("FAIL idle_after_reset: busy=%b gameSig=%b want 0/0", bus.busy, bus.gameSig); end
  endtask

  task automatic test_start();
    bit ok; int lat;
    start_game(ok, lat);
    model_new_game();
    n_tests++; if (!ok || lat < 1 || lat > 2) begin n_fail++; $display("FAIL start_latency: got %0d cycles ok=%0b want 1..2", lat, ok); end
    n_tests++; if (bus.busy !== 1'b1) begin n_fail++; $display("FAIL start_busy: got %b want 1", bus.busy); end
    n_tests++; if (bus.symGenMax !== 32'(BASE) || bus.score !== 16'd0) begin
      n_fail++; $display("FAIL start_values: sym=%0d score=%0d want %0d/0", bus.symGenMax, bus.score, BASE);
    end
    tick();
    n_tests++; if (bus.gameSig !== 1'b0 || bus.busy !== 1'b1) begin n_fail++; $display("FAIL gamesig_width: gameSig=%b busy=%b want 0/1", bus.gameSig, bus.busy); end
  endtask

  task automatic test_first_round();
    bit ok; int ans, hold, d; logic corr; logic [15:0] sc; logic [3:0] lv, rd; logic [31:0] sym;
    d = $urandom_range(0, 10);
    play_round(1'b1, 8'd5, 1'b1, 8'd5, d, 1'b0, ok, ans, hold, corr, sc, lv, sym, rd);
    model_round(1'b1);
    n_tests++; if (!ok) begin n_fail++; $display("FAIL r1_handshake: result never appeared, want RESULT"); end
    n_tests++; if (corr !== 1'b1 || sc !== 16'd1 || lv !== 4'd1) begin n_fail++; $display("FAIL r1_verdict: corr=%b score=%0d level=%0d want 1/1/1", corr, sc, lv); end
    n_tests++; if (sym !== 32'd800 || rd !== 4'd1) begin n_fail++; $display("FAIL r1_sym_round: sym=%0d round=%0d want 800/1", sym, rd); end
    n_tests++; if (ans !== d + 2) begin n_fail++; $display("FAIL r1_answer_len: got %0d want %0d", ans, d + 2); end
    n_tests++; if (hold !== HOLD) begin n_fail++; $display("FAIL r1_hold: got %0d want %0d", hold, HOLD); end
    n_tests++; if (bus.gameSig !== 1'b1) begin n_fail++; $display("FAIL r1_next_start: gameSig=%b want 1", bus.gameSig); end
  endtask

  task automatic test_full_game();
    bit ok; int ans, hold; logic corr; logic [15:0] sc; logic [3:0] lv, rd; logic [31:0] sym;
    logic [7:0] ns;
    int exp_score [2] = '{3, 6};
    int exp_sym   [2] = '{600, 400};
    for (int r = 0; r < 2; r++) begin
      ns = 8'($urandom);
      play_round(1'b0, ns, 1'b1, ns, $urandom_range(0, 20), 1'b0, ok, ans, hold, corr, sc, lv, sym, rd);
      model_round(1'b1);
      n_tests++; if (!ok || corr !== 1'b1) begin n_fail++; $display("FAIL full_r%0d_correct: ok=%0b corr=%b want 1", r + 2, ok, corr); end
      n_tests++; if (sc !== 16'(exp_score[r]) || lv !== 4'(r + 2)) begin n_fail++; $display("FAIL full_r%0d_score_level: %0d/%0d want %0d/%0d", r + 2, sc, lv, exp_score[r], r + 2); end
      n_tests++; if (sym !== 32'(exp_sym[r]) || rd !== 4'(r + 2)) begin n_fail++; $display("FAIL full_r%0d_sym_round: %0d/%0d want %0d/%0d", r + 2, sym, rd, exp_sym[r], r + 2); end
    end
    n_tests++; if (bus.gameOver !== 1'b1 || bus.gameSig !== 1'b0) begin n_fail++; $display("FAIL game_over: gameOver=%b gameSig=%b want 1/0", bus.gameOver, bus.gameSig); end
    tick(5);
    n_tests++; if (bus.gameOver !== 1'b1 || bus.gameSig !== 1'b0 || bus.score !== 16'd6) begin
      n_fail++; $display("FAIL done_hold: gameOver=%b gameSig=%b score=%0d want 1/0/6", bus.gameOver, bus.gameSig, bus.score);
    end
  endtask

  task automatic test_restart();
    bit ok; int lat;
    start_game(ok, lat);
    model_new_game();
    n_tests++; if (!ok || lat > 2) begin n_fail++; $display("FAIL restart_latency: got %0d ok=%0b want <=2", lat, ok); end
    n_tests++; if (bus.score !== 16'd0 || bus.level !== 4'd0 || bus.roundIdx !== 4'd0) begin
      n_fail++; $display("FAIL restart_clear: score=%0d level=%0d round=%0d want 0/0/0", bus.score, bus.level, bus.roundIdx);
    end
    n_tests++; if (bus.gameOver !== 1'b0 || bus.symGenMax !== 32'(BASE)) begin n_fail++; $display("FAIL restart_flags: gameOver=%b sym=%0d want 0/%0d", bus.gameOver, bus.symGenMax, BASE); end
  endtask

  task automatic test_timeout();
    bit ok; int ans, hold; logic corr; logic [15:0] sc; logic [3:0] lv, rd; logic [31:0] sym;
    logic [7:0] ns;
    ns = 8'($urandom);
    play_round(1'b0, ns, 1'b0, ns, 0, 1'b1, ok, ans, hold, corr, sc, lv, sym, rd);
    model_round(1'b0);
    n_tests++; if (!ok || corr !== 1'b0) begin n_fail++; $display("FAIL timeout_verdict: ok=%0b corr=%b want 0", ok, corr); end
    n_tests++; if (lv !== 4'd0 || sym !== 32'(BASE) || sc !== 16'd0) begin n_fail++; $display("FAIL timeout_floor: level=%0d sym=%0d score=%0d want 0/%0d/0", lv, sym, sc, BASE); end
    n_tests++; if (ans !== TMO + 1) begin n_fail++; $display("FAIL timeout_window: got %0d want %0d", ans, TMO + 1); end
    n_tests++; if (hold !== HOLD || bus.correct !== 1'b0) begin n_fail++; $display("FAIL late_guess: hold=%0d corr=%b want %0d/0", hold, bus.correct, HOLD); end
    ns = 8'($urandom);
    play_round(1'b0, ns, 1'b1, ns, TMO - 1, 1'b0, ok, ans, hold, corr, sc, lv, sym, rd);
    model_round(1'b1);
    n_tests++; if (!ok || corr !== 1'b1 || ans !== TMO + 1) begin n_fail++; $display("FAIL expiry_guess: corr=%b window=%0d want 1/%0d", corr, ans, TMO + 1); end
    n_tests++; if (sc !== 16'(m_score) || lv !== 4'(m_level) || sym !== 32'(m_sym)) begin
      n_fail++; $display("FAIL expiry_state: %0d/%0d/%0d want %0d/%0d/%0d", sc, lv, sym, m_score, m_level, m_sym);
    end
    play_round(1'b0, ns, 1'b1, ns + 8'd1, $urandom_range(0, 30), 1'b0, ok, ans, hold, corr, sc, lv, sym, rd);
    model_round(1'b0);
    n_tests++; if (!ok || corr !== 1'b0 || lv !== 4'(m_level) || sym !== 32'(m_sym) || sc !== 16'(m_score)) begin
      n_fail++; $display("FAIL wrong_guess: corr=%b %0d/%0d/%0d want 0/%0d/%0d/%0d", corr, sc, lv, sym, m_score, m_level, m_sym);
    end
    n_tests++; if (bus.gameOver !== 1'b1) begin n_fail++; $display("FAIL timeout_game_over: got %b want 1", bus.gameOver); end
  endtask

  task automatic test_random();
    bit ok; int ans, hold, kind, d, lat; logic corr; logic [15:0] sc; logic [3:0] lv, rd; logic [31:0] sym;
    logic [7:0] ns, g;
    for (int gm = 0; gm < 4; gm++) begin
      start_game(ok, lat);
      model_new_game();
      n_tests++; if (!ok) begin n_fail++; $display("FAIL rand_g%0d_start: no gameSig, want pulse", gm); end
      for (int r = 0; r < ROUNDS; r++) begin
        kind = $urandom_range(0, 2);
        ns   = 8'($urandom);
        g    = (kind == 0) ? ns : ns ^ 8'(1 << $urandom_range(0, 7));
        d    = $urandom_range(0, TMO - 1);
        play_round(1'b0, ns, kind != 2, g, d, 1'b0, ok, ans, hold, corr, sc, lv, sym, rd);
        model_round(kind == 0);
        n_tests++; if (!ok || corr !== (kind == 0)) begin n_fail++; $display("FAIL rand_g%0d_r%0d_corr: got %b want %0d", gm, r, corr, kind == 0); end
        n_tests++; if (sc !== 16'(m_score) || lv !== 4'(m_level) || sym !== 32'(m_sym) || rd !== 4'(m_round)) begin
          n_fail++; $display("FAIL rand_g%0d_r%0d_state: %0d/%0d/%0d/%0d want %0d/%0d/%0d/%0d", gm, r, sc, lv, sym, rd, m_score, m_level, m_sym, m_round);
        end
        n_tests++; if (ans !== ((kind == 2) ? TMO + 1 : d + 2) || hold !== HOLD) begin
          n_fail++; $display("FAIL rand_g%0d_r%0d_timing: window=%0d hold=%0d want %0d/%0d", gm, r, ans, hold, (kind == 2) ? TMO + 1 : d + 2, HOLD);
        end
      end
      n_tests++; if (bus.gameOver !== 1'b1) begin n_fail++; $display("FAIL rand_g%0d_over: got %b want 1", gm, bus.gameOver); end
    end
  endtask

  task automatic test_abort();
    bit ok; int ans, hold, lat; logic corr; logic [15:0] sc; logic [3:0] lv, rd; logic [31:0] sym;
    start_game(ok, lat);
    model_new_game();
    play_round(1'b0, 8'd9, 1'b1, 8'd9, 3, 1'b0, ok, ans, hold, corr, sc, lv, sym, rd);
    model_round(1'b1);
    tick();
    bus.abortBtn = 1'b1;
    tick();
    bus.abortBtn = 1'b0;
    n_tests++; if (bus.busy !== 1'b0 || bus.resultValid !== 1'b0 || bus.gameOver !== 1'b0) begin
      n_fail++; $display("FAIL abort_flags: busy=%b rv=%b over=%b want 0/0/0", bus.busy, bus.resultValid, bus.gameOver);
    end
    n_tests++; if (bus.score !== 16'(m_score) || bus.level !== 4'(m_level) || bus.roundIdx !== 4'(m_round)) begin
      n_fail++; $display("FAIL abort_retain: %0d/%0d/%0d want %0d/%0d/%0d", bus.score, bus.level, bus.roundIdx, m_score, m_level, m_round);
    end
    bus.answerSig = 1'b1;
    tick();
    bus.answerSig = 1'b0;
    tick(3);
    n_tests++; if (bus.busy !== 1'b0 || bus.gameSig !== 1'b0 || bus.resultValid !== 1'b0) begin
      n_fail++; $display("FAIL abort_answer_ignored: busy=%b gameSig=%b rv=%b want 0/0/0", bus.busy, bus.gameSig, bus.resultValid);
    end
  endtask

  task automatic test_async_reset();
    bit ok, saw_sig; int ans, hold, lat; logic corr; logic [15:0] sc; logic [3:0] lv, rd; logic [31:0] sym;
    start_game(ok, lat);
    play_round(1'b0, 8'd3, 1'b1, 8'd3, 2, 1'b0, ok, ans, hold, corr, sc, lv, sym, rd);
    tick();
    bus.numSpecial = 8'd4;
    bus.answerSig  = 1'b1;
    tick();
    bus.answerSig  = 1'b0;
    tick(2);
    n_tests++; if (bus.busy !== 1'b1 || bus.score !== 16'd1) begin n_fail++; $display("FAIL pre_reset: busy=%b score=%0d want 1/1", bus.busy, bus.score); end
    #2;
    rst_n = 1'b0;
    #1;
    n_tests++; if (bus.score !== 16'd0 || bus.level !== 4'd0 || bus.roundIdx !== 4'd0 || bus.symGenMax !== 32'(BASE)) begin
      n_fail++; $display("FAIL async_reset_vals: %0d/%0d/%0d/%0d want 0/0/0/%0d", bus.score, bus.level, bus.roundIdx, bus.symGenMax, BASE);
    end
    n_tests++; if ({bus.gameSig, bus.busy, bus.resultValid, bus.correct, bus.gameOver} !== 5'b0) begin
      n_fail++; $display("FAIL async_reset_flags: got %b want 00000", {bus.gameSig, bus.busy, bus.resultValid, bus.correct, bus.gameOver});
    end
    bus.startBtn = 1'b0;
    saw_sig = 1'b0;
    for (int i = 0; i < 4; i++) begin tick(); if (bus.gameSig !== 1'b0) saw_sig = 1'b1; end
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin tick(); if (bus.gameSig !== 1'b0) saw_sig = 1'b1; end
    n_tests++; if (saw_sig || bus.busy !== 1'b0) begin n_fail++; $display("FAIL reset_no_gamesig: saw=%0b busy=%b want 0/0", saw_sig, bus.busy); end
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    bus.startBtn   = 1'b0;
    bus.abortBtn   = 1'b0;
    bus.answerSig  = 1'b0;
    bus.numSpecial = 8'd0;
    bus.guessValid = 1'b0;
    bus.guess      = 8'd0;
    test_reset();
    test_start();
    test_first_round();
    test_full_game();
    test_restart();
    test_timeout();
    test_random();
    test_abort();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
